vga_scanout: RTL and testbench
==============================

// Module: vga_scanout
// PURPOSE
//  Read side of the 160x120x3 game framebuffer. Generates 640x480@60 VGA timing from
//  clk (50 MHz) and reads each framebuffer pixel through a 1-cycle-latency RAM read port.
//  Each framebuffer pixel is scaled 4x4 on screen. Drives the DAC/sync pins, replacing the
//  scan-out half of vga_adapter; display writes the same RAM through the other port.
// PARAMETERS
//  H_VIS 640 visible px/line;  H_FP 16;  H_SW 96;  H_BP 48   (H_TOT = 800)
//  V_VIS 480 visible lines;    V_FP 10;  V_SW 2;   V_BP 33   (V_TOT = 525)
//  FB_W  160  framebuffer width in px; FB_H 120 framebuffer height in px
//  SHIFT 2    log2 of the scale factor (screen px per fb px)
// PORTS
//  clk          in   1   system clock, 50 MHz
//  reset        in   1   synchronous, active-high
//  fb_addr      out  15  framebuffer read address = y*160 + x
//  fb_rd_en     out  1   read strobe; high one clk per visible pixel tick
//  fb_data      in   3   {R,G,B} from RAM, valid the clk after fb_rd_en
//  vga_clk      out  1   25 MHz pixel clock = registered copy of pix_ce
//  vga_hs       out  1   hsync, active low
//  vga_vs       out  1   vsync, active low
//  vga_blank_n  out  1   high only while a visible pixel is on the pins
//  vga_sync_n   out  1   tied 0
//  vga_r/g/b    out  10  each colour bit replicated to all 10 bits
//  frame_start  out  1   one-clk pulse at the start of each frame
// BEHAVIOUR
//  - pix_ce: internal toggle. It is 0 in the first clk after reset, then alternates.
//    All timing advances only on clks with pix_ce=1 ("ticks").
//  - Counters: h 0..799, v 0..524. On each tick h++. At h=799, h->0 and v++.
//    At v=524 and h=799, v->0. visible = (h<640) && (v<480).
//  - Stage 1 (tick): if visible, fb_addr <= (v>>2)*160 + (h>>2) and fb_rd_en=1.
//    The multiply is done as (y<<7)+(y<<5)+x with no multiplier.
//    If not visible, fb_addr holds its value and fb_rd_en=0. fb_rd_en is low on non-tick clks.
//    Stage 1 also registers hs_raw, vs_raw and vis.
//    hs_raw is active for 656<=h<=751. vs_raw is active for 490<=v<=491.
//  - Stage 2 (next tick): vga_r/g/b <= vis_d ? replicate(fb_data) : 0.
//    fb_data is sampled in the clk before this tick (RAM latency 1).
//    vga_hs, vga_vs and vga_blank_n are updated from their stage-1 copies at the same tick.
//    Pin latency is therefore 2 ticks (4 clks) after the counters, identical for colour and syncs.
//  - Colour map: fb_data[2] drives R, [1] drives G, [0] drives B.
//    Example: 3'b101 gives R=3FF, G=000, B=3FF.
//  - frame_start: high for exactly one clk, on the tick where the counters wrap (799,524)->(0,0).
//  - Reset (any time, including mid-line): h=v=0, pix_ce=0, fb_addr=0, fb_rd_en=0,
//    vga_hs=vga_vs=1, vga_blank_n=0, rgb=0, frame_start=0, vga_clk=0, pipeline regs cleared.
//    The first frame after reset starts cleanly at (0,0). No partial-frame state survives.
//  - Blanking: colour is forced to 0 whenever vis_d=0, whatever fb_data is.
//  - Last visible pixel: at (639,479), fb_addr = 119*160 + 159 = 19199. No address >= 19200 is ever issued.
// TESTING
//  1 Reset held 3 clks, then released -> all outputs at their reset values.
//    First fb_rd_en on clk 2 after release, with fb_addr=0.
//  2 Free run with a RAM model -> hs low for 192 clks every 1600 clks, vs low for 3200 clks every 840000 clks.
//    frame_start spacing is 840000 clks.
//  3 RAM model returns data = addr[2:0] -> screen px (4..7, 0) shows data 1 (B=3FF).
//    px (8, 4) reads addr 162 and shows 3'b010.
//    The colour edge on the pins is 4 clks after the counter edge.
//  4 fb_data forced to 3'b111 throughout -> rgb = 0 whenever blank_n = 0.
//    rgb = 3FF for exactly 640 ticks per visible line and 0 elsewhere.
//  5 Reset asserted at h=700, v=200 for 1 clk -> next frame_start occurs exactly 840000 clks later.
//    No fb_rd_en is issued during reset.
//  6 Address sweep over a full frame -> the max fb_addr is 19199 and each address is read 16 times per frame.

Source files
------------

// File: rtl/vga_scanout.sv
// vga_scanout: read side of the 160x120x3 framebuffer. Generates 640x480@60 VGA timing
// from a 50 MHz clock, fetches one framebuffer pixel per visible pixel tick through a
// 1-cycle-latency RAM port, scales each framebuffer pixel 4x4 and drives the DAC/sync pins.
// Colour and sync pins share one pipeline, so they line up 2 ticks behind the counters.
module vga_scanout #(
  parameter int H_VIS = 640,
  parameter int H_FP  = 16,
  parameter int H_SW  = 96,
  parameter int H_BP  = 48,
  parameter int V_VIS = 480,
  parameter int V_FP  = 10,
  parameter int V_SW  = 2,
  parameter int V_BP  = 33,
  parameter int SHIFT = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [14:0] fb_addr_o,
  output logic        fb_rd_en_o,
  input  logic [2:0]  fb_data_i,
  output logic        vga_clk_o,
  output logic        vga_hs_o,
  output logic        vga_vs_o,
  output logic        vga_blank_n_o,
  output logic        vga_sync_n_o,
  output logic [9:0]  vga_r_o,
  output logic [9:0]  vga_g_o,
  output logic [9:0]  vga_b_o,
  output logic        frame_start_o
);

  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int H_SS  = H_VIS + H_FP;
  localparam int H_SE  = H_VIS + H_FP + H_SW - 1;
  localparam int V_SS  = V_VIS + V_FP;
  localparam int V_SE  = V_VIS + V_FP + V_SW - 1;

  logic        pix_ce_q;
  logic        vga_clk_q;
  logic [9:0]  h_q, v_q;
  logic        rd_en_q;
  logic [14:0] addr_q;
  logic        frame_start_q;
  logic        vis_q, hs_act_q, vs_act_q;
  logic        hs_q, vs_q, blank_n_q;
  logic [9:0]  r_q, g_q, b_q;

  // Position decode of the current counter values.
  logic        visible;
  logic        at_wrap;
  logic        hs_act, vs_act;
  logic [14:0] fb_x, fb_y, addr_d;

  assign visible = (h_q < 10'(H_VIS)) && (v_q < 10'(V_VIS));
  assign at_wrap = (h_q == 10'(H_TOT - 1)) && (v_q == 10'(V_TOT - 1));
  assign hs_act  = (h_q >= 10'(H_SS)) && (h_q <= 10'(H_SE));
  assign vs_act  = (v_q >= 10'(V_SS)) && (v_q <= 10'(V_SE));

  // Row stride of 160 = 128 + 32, built from shifts so no multiplier is needed.
  assign fb_x   = 15'(h_q >> SHIFT);
  assign fb_y   = 15'(v_q >> SHIFT);
  assign addr_d = (fb_y << 7) + (fb_y << 5) + fb_x;

  // Pixel-clock enable toggle and its registered copy for the DAC clock pin.
  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_ce_q  <= 1'b0;
      vga_clk_q <= 1'b0;
    end else begin
      pix_ce_q  <= ~pix_ce_q;
      vga_clk_q <= pix_ce_q;
    end
  end

  // Horizontal/vertical counters advance once per tick and wrap at the frame end.
  // NOTE: reset is synchronous and clears every register, pipeline included, so no
  // partial-frame state survives a mid-frame reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_ce_q) begin
      if (h_q == 10'(H_TOT - 1)) begin
        h_q <= '0;
        v_q <= (v_q == 10'(V_TOT - 1)) ? '0 : v_q + 10'd1;
      end else begin
        h_q <= h_q + 10'd1;
      end
    end
  end

  // Read request and frame marker are registered on the edge just before a tick, so they
  // sit on the pins for exactly the tick clk and the RAM latches the address at the tick edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en_q       <= 1'b0;
      addr_q        <= '0;
      frame_start_q <= 1'b0;
    end else if (!pix_ce_q) begin
      rd_en_q       <= visible;
      frame_start_q <= at_wrap;
      if (visible) begin
        addr_q <= addr_d;
      end
    end else begin
      rd_en_q       <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  // Stage 1: capture visibility and raw sync flags of the pixel being fetched.
  always_ff @(posedge clk) begin
    if (reset) begin
      vis_q    <= 1'b0;
      hs_act_q <= 1'b0;
      vs_act_q <= 1'b0;
    end else if (pix_ce_q) begin
      vis_q    <= visible;
      hs_act_q <= hs_act;
      vs_act_q <= vs_act;
    end
  end

  // Stage 2: RAM data is valid by now; drive colour and syncs together.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else if (pix_ce_q) begin
      hs_q      <= ~hs_act_q;
      vs_q      <= ~vs_act_q;
      blank_n_q <= vis_q;
      r_q       <= vis_q ? {10{fb_data_i[2]}} : 10'd0;
      g_q       <= vis_q ? {10{fb_data_i[1]}} : 10'd0;
      b_q       <= vis_q ? {10{fb_data_i[0]}} : 10'd0;
    end
  end

  assign fb_addr_o     = addr_q;
  assign fb_rd_en_o    = rd_en_q;
  assign frame_start_o = frame_start_q;
  assign vga_clk_o     = vga_clk_q;
  assign vga_hs_o      = hs_q;
  assign vga_vs_o      = vs_q;
  assign vga_blank_n_o = blank_n_q;
  assign vga_sync_n_o  = 1'b0;
  assign vga_r_o       = r_q;
  assign vga_g_o       = g_q;
  assign vga_b_o       = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Testbench for vga_scanout. The DUT runs with a shrunken timing set so several whole
// frames fit in a short run; every expectation is derived from the generic timing rules.
// The reference model works from a clk count since reset: tick number, screen position,
// and the RAM contents are plain arithmetic, not a copy of the RTL pipeline.
module tb_vga_scanout;

  localparam int H_VIS = 32, H_FP = 4, H_SW = 8, H_BP = 4;
  localparam int V_VIS = 24, V_FP = 2, V_SW = 2, V_BP = 2;
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int TOT   = H_TOT * V_TOT;

  logic        clk;
  logic        reset;
  logic [14:0] fb_addr;
  logic        fb_rd_en;
  logic [2:0]  fb_data;
  logic        vga_clk, vga_hs, vga_vs, vga_blank_n, vga_sync_n, frame_start;
  logic [9:0]  vga_r, vga_g, vga_b;

  vga_scanout #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP), .SHIFT(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .fb_addr_o    (fb_addr),
    .fb_rd_en_o   (fb_rd_en),
    .fb_data_i    (fb_data),
    .vga_clk_o    (vga_clk),
    .vga_hs_o     (vga_hs),
    .vga_vs_o     (vga_vs),
    .vga_blank_n_o(vga_blank_n),
    .vga_sync_n_o (vga_sync_n),
    .vga_r_o      (vga_r),
    .vga_g_o      (vga_g),
    .vga_b_o      (vga_b),
    .frame_start_o(frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int c     = 1;   // clk index since the last edge that sampled reset high
  int mode  = 0;   // 0: data = addr[2:0], 1: all white, 2: scrambled by seed
  int seed  = 0;

  // Framebuffer contents as a function of address.
  function automatic int mem_val(int addr);
    case (mode)
      0:       return addr & 7;
      1:       return 7;
      default: return ((addr * 5) ^ (addr >> 3) ^ seed) & 7;
    endcase
  endfunction

  // RAM read port with one clk of latency.
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= 3'(mem_val(int'(fb_addr)));
  end

  function automatic bit pos_vis(int p);
    return ((p % H_TOT) < H_VIS) && ((p / H_TOT) < V_VIS);
  endfunction

  function automatic int pos_addr(int p);
    return ((p / H_TOT) / 4) * 160 + (p % H_TOT) / 4;
  endfunction

  function automatic bit pos_hs_low(int p);
    int h;
    h = p % H_TOT;
    return (h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SW);
  endfunction

  function automatic bit pos_vs_low(int p);
    int v;
    v = p / H_TOT;
    return (v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SW);
  endfunction

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
    if (bad >= 40) finish_run();
  endtask

  // Compare every output against the model for clk index c.
  task automatic check_cycle();
    int  n, p, m, q, d;
    bit  exp_rd, exp_fs, exp_vclk, exp_blank, exp_hs, exp_vs;
    logic [9:0] er, eg, eb;
    // Ticks are the even clks; tick k is in clk 2k+2 and counters reflect k ticks done.
    n        = (c - 1) / 2;
    p        = n % TOT;
    exp_vclk = (c >= 3) && (c % 2 == 1);
    exp_rd   = (c % 2 == 0) && pos_vis(p);
    exp_fs   = (c % 2 == 0) && (p == TOT - 1);
    exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0;
    er = '0; eg = '0; eb = '0;
    if (c >= 5) begin
      // Pins show the pixel of tick m two ticks (4 clks) after it was on the counters.
      m = (c - 5) / 2;
      q = m % TOT;
      exp_hs    = !pos_hs_low(q);
      exp_vs    = !pos_vs_low(q);
      exp_blank = pos_vis(q);
      if (exp_blank) begin
        d  = mem_val(pos_addr(q));
        er = (d & 4) != 0 ? 10'h3FF : 10'h000;
        eg = (d & 2) != 0 ? 10'h3FF : 10'h000;
        eb = (d & 1) != 0 ? 10'h3FF : 10'h000;
      end
    end
    check("vga_clk",     32'(vga_clk),     32'(exp_vclk));
    check("fb_rd_en",    32'(fb_rd_en),    32'(exp_rd));
    if (exp_rd) check("fb_addr", 32'(fb_addr), 32'(pos_addr(p)));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("vga_hs",      32'(vga_hs),      32'(exp_hs));
    check("vga_vs",      32'(vga_vs),      32'(exp_vs));
    check("vga_blank_n", 32'(vga_blank_n), 32'(exp_blank));
    check("vga_sync_n",  32'(vga_sync_n),  32'd0);
    check("vga_r",       32'(vga_r),       32'(er));
    check("vga_g",       32'(vga_g),       32'(eg));
    check("vga_b",       32'(vga_b),       32'(eb));
  endtask

  // Hold reset for k clks, checking reset values each clk; c=1 is the clk after release.
  task automatic do_reset(int k);
    reset = 1'b1;
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      @(negedge clk);
      c = 1;
      check_cycle();
    end
    reset = 1'b0;
  endtask

  int rd_cnt[0:19199];

  // Run n clks against the model; optionally gather one full frame of statistics over
  // the window (2*TOT, 4*TOT], which lies between two frame_start pulses.
  task automatic run(int ncyc, bit stats);
    int fs_cnt, hs_low, vs_low, rd_tot, max_addr, n16, white;
    fs_cnt = 0; hs_low = 0; vs_low = 0; rd_tot = 0; max_addr = 0; n16 = 0; white = 0;
    for (int i = 0; i < 19200; i++) rd_cnt[i] = 0;
    for (int i = 0; i < ncyc; i++) begin
      @(posedge clk);
      c++;
      @(negedge clk);
      check_cycle();
      if (stats && c > 2 * TOT && c <= 4 * TOT) begin
        if (frame_start) fs_cnt++;
        if (!vga_hs) hs_low++;
        if (!vga_vs) vs_low++;
        if (vga_r == 10'h3FF && vga_g == 10'h3FF && vga_b == 10'h3FF) white++;
        if (fb_rd_en) begin
          rd_tot++;
          if (int'(fb_addr) > max_addr) max_addr = int'(fb_addr);
          if (int'(fb_addr) < 19200) rd_cnt[int'(fb_addr)]++;
        end
      end
    end
    if (stats) begin
      for (int i = 0; i < 19200; i++) if (rd_cnt[i] == 16) n16++;
      check("frame_start_per_frame", 32'(fs_cnt),   32'd1);
      check("hs_low_clks_per_frame", 32'(hs_low),   32'(2 * H_SW * V_TOT));
      check("vs_low_clks_per_frame", 32'(vs_low),   32'(2 * V_SW * H_TOT));
      check("reads_per_frame",       32'(rd_tot),   32'(H_VIS * V_VIS));
      check("max_fb_addr",           32'(max_addr), 32'((V_VIS / 4 - 1) * 160 + H_VIS / 4 - 1));
      check("addrs_read_16_times",   32'(n16),      32'((H_VIS / 4) * (V_VIS / 4)));
      if (mode == 1) check("white_clks_per_frame", 32'(white), 32'(2 * H_VIS * V_VIS));
    end
  endtask

  initial begin
    reset = 1'b1;

    // Power-up reset, then data = addr[2:0] over several frames.
    mode = 0;
    do_reset(3);
    run(4 * TOT - 1, 1'b1);

    // All-white framebuffer: colour must follow blanking exactly.
    mode = 1;
    do_reset(2);
    run(4 * TOT - 1, 1'b1);

    // Scrambled data, then a 1-clk reset at a random point mid-frame.
    mode = 2;
    seed = int'($urandom_range(0, 7));
    do_reset(1);
    run(int'($urandom_range(TOT / 2, 2 * TOT)), 1'b0);
    seed = int'($urandom_range(0, 7));
    do_reset(1);
    run(4 * TOT - 1, 1'b1);

    // A few more random mid-frame resets with fresh data patterns.
    for (int k = 0; k < 3; k++) begin
      run(int'($urandom_range(10, TOT)), 1'b0);
      seed = int'($urandom_range(0, 7));
      do_reset(int'($urandom_range(1, 3)));
    end
    run(2 * TOT + 20, 1'b0);

    finish_run();
  end

endmodule
